// File: rtl/inst_seq.sv
// -----------------------------------------------------------------------------
// inst_seq -- tile-run instruction sequencer for a row x col PE array.
//
// One accepted start runs a complete tile: fetch col weight words from xmem
// into L0, load them into the array, let them settle, fetch xlen activation
// words, execute, then drain xlen output vectors from the output FIFO into
// psum memory. Every cycle the sequencer presents one registered 35-bit core
// instruction word.
//
// The state/counter registers describe the word currently on inst. Each edge
// computes the next state and counters and, from those, the next word, so
// inst, busy and done line up with the state they belong to.
//
// Ports:
//   clk          single clock, all state on the rising edge
//   reset        asynchronous, active-high
//   start        tile-run request, sampled in IDLE only
//   mode         0 = WS, 1 = OS; latched at an accepted start, drives inst[34]
//   w_base       xmem address of the first weight word
//   x_base       xmem address of the first activation word
//   p_base       psum-memory address of the first output vector
//   ofifo_valid  output FIFO head holds a vector
//   inst         registered core instruction word
//                [34] mode [33] acc [32] psum CEN [31] psum WEN [30:20] psum addr
//                [19] xmem CEN [18] xmem WEN [17:7] xmem addr
//                [6] ofifo_rd [5] ififo_wr [4] ififo_rd [3] l0_rd [2] l0_wr
//                [1] execute [0] load   (CEN/WEN active-low, strobes active-high)
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse (the DONE state)
// -----------------------------------------------------------------------------
module inst_seq #(
  parameter int row  = 8,
  parameter int col  = 8,
  parameter int xlen = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [10:0] w_base,
  input  logic [10:0] x_base,
  input  logic [10:0] p_base,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        busy,
  output logic        done
);

  // Longest phase is a read phase (len+1 cycles); the counter must hold it.
  localparam int rdMax  = ((xlen > col) ? xlen : col) + 1;
  localparam int cntMax = (rdMax > row) ? rdMax : row;
  localparam int cntW   = $clog2(cntMax + 1);

  // CEN/WEN high, addresses and strobes zero, mode bit zero.
  localparam logic [34:0] idleWord = 35'h1800C0000;

  typedef enum logic [2:0] {
    IDLE, W_RD, W_LOAD, W_WAIT, X_RD, EXEC, DRAIN, DONE
  } state_t;

  state_t            state, nextState;
  logic [cntW-1:0]   cnt, nextCnt;
  logic              drainWr, nextWr;   // current DRAIN word is a psum write
  logic              modeQ, nextMode;
  logic [34:0]       nextInst;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned -- that is what keeps this block from inferring latches.
    nextState = state;
    nextCnt   = cnt;
    nextWr    = 1'b0;
    nextMode  = modeQ;
    nextInst  = idleWord;

    unique case (state)
      IDLE: begin
        if (start) begin
          nextState = W_RD;
          nextCnt   = '0;
          nextMode  = mode;
        end
      end
      W_RD: begin
        if (cnt == cntW'(col)) begin
          nextState = W_LOAD;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + cntW'(1);
        end
      end
      W_LOAD: begin
        if (cnt == cntW'(col - 1)) begin
          nextState = W_WAIT;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + cntW'(1);
        end
      end
      W_WAIT: begin
        if (cnt == cntW'(row - 1)) begin
          nextState = X_RD;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + cntW'(1);
        end
      end
      X_RD: begin
        if (cnt == cntW'(xlen)) begin
          nextState = EXEC;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + cntW'(1);
        end
      end
      EXEC: begin
        if (cnt == cntW'(xlen - 1)) begin
          nextState = DRAIN;
          nextCnt   = '0;
          nextWr    = ofifo_valid;
        end else begin
          nextCnt = cnt + cntW'(1);
        end
      end
      DRAIN: begin
        // cnt is the psum index of the current (or next pending) write; it
        // only advances once the current word actually wrote.
        if (drainWr && cnt == cntW'(xlen - 1)) begin
          nextState = DONE;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + cntW'(drainWr);
          nextWr  = ofifo_valid;
        end
      end
      DONE: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase

    // Word for the state being entered.
    nextInst[34] = nextMode;
    unique case (nextState)
      W_RD: begin
        if (nextCnt < cntW'(col)) begin
          nextInst[19]   = 1'b0;
          nextInst[17:7] = w_base + 11'(nextCnt);
        end
        // SRAM data arrives one cycle after the read, so L0 writes lag by one.
        if (nextCnt != '0) nextInst[2] = 1'b1;
      end
      X_RD: begin
        if (nextCnt < cntW'(xlen)) begin
          nextInst[19]   = 1'b0;
          nextInst[17:7] = x_base + 11'(nextCnt);
        end
        if (nextCnt != '0) nextInst[2] = 1'b1;
      end
      W_LOAD: begin
        nextInst[3] = 1'b1;
        nextInst[0] = 1'b1;
      end
      EXEC: begin
        nextInst[3] = 1'b1;
        nextInst[1] = 1'b1;
      end
      DRAIN: begin
        if (nextWr) begin
          nextInst[6]     = 1'b1;
          nextInst[32]    = 1'b0;
          nextInst[31]    = 1'b0;
          nextInst[30:20] = p_base + 11'(nextCnt);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      drainWr <= 1'b0;
      modeQ   <= 1'b0;
      inst    <= idleWord;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nextState;
      cnt     <= nextCnt;
      drainWr <= nextWr;
      modeQ   <= nextMode;
      inst    <= nextInst;
      busy    <= (nextState != IDLE);
      done    <= (nextState == DONE);
    end
  end

endmodule

// File: tb/tb_inst_seq.sv
// -----------------------------------------------------------------------------
// tb_inst_seq -- scoreboard bench for inst_seq (row = 8, col = 8, xlen = 36).
//
// Stimulus tasks push the expected xmem read addresses and psum write
// addresses into queues when a run is issued; a monitor on the falling edge
// pops and compares whenever the DUT asserts a memory access, and checks the
// strobe pattern against the fixed phase windows of a run (cycle 1 = first
// busy cycle):
//   W_RD 1..9  W_LOAD 10..17  W_WAIT 18..25  X_RD 26..62  EXEC 63..98
//   DRAIN 99..  then the DONE cycle.
// -----------------------------------------------------------------------------
module tb_inst_seq;

  localparam logic [34:0] idleWord = 35'h1800C0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [10:0] w_base;
  logic [10:0] x_base;
  logic [10:0] p_base;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy;
  logic        done;

  inst_seq #(.row(8), .col(8), .xlen(36)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] xq[$];
  logic [10:0] pq[$];
  logic        expMode = 1'b0;
  int          expBusy = 0;     // busy cycles before done; 0 = not checked
  int          doneCount = 0;
  int          cyc = 0;
  logic        validAtEdge = 1'b0;
  logic        prevDone = 1'b0;
  logic        lw, ld, ex, xr, pw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [34:0] idleFor(input logic m);
    logic [34:0] w;
    w     = idleWord;
    w[34] = m;
    return w;
  endfunction

  // ofifo_valid as the DUT saw it at the most recent rising edge.
  always @(posedge clk) validAtEdge <= ofifo_valid;

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      cyc      = 0;
      prevDone = 1'b0;
    end else begin
      if (prevDone) check("busy_after_done", busy, 1'b0);
      prevDone = done;
      if (!busy) begin
        cyc = 0;
        check("idle_word", inst, idleFor(expMode));
        check("idle_done", done, 1'b0);
      end else begin
        cyc++;
        check("mode_bit", inst[34], expMode);
        check("acc_ififo", {inst[33], inst[5], inst[4]}, 3'b000);
        if (done) begin
          doneCount++;
          check("done_word", inst, idleFor(expMode));
          if (expBusy != 0) check("busy_len", cyc - 1, expBusy);
          check("xq_empty", xq.size(), 0);
          check("pq_empty", pq.size(), 0);
        end else begin
          lw = (cyc >= 2 && cyc <= 9) || (cyc >= 27 && cyc <= 62);
          ld = (cyc >= 10 && cyc <= 17);
          ex = (cyc >= 63 && cyc <= 98);
          xr = (cyc >= 1 && cyc <= 8) || (cyc >= 26 && cyc <= 61);
          pw = (cyc >= 99) && validAtEdge;
          check("strobes", {inst[6], inst[3], inst[2], inst[1], inst[0]},
                {pw, ld | ex, lw, ex, ld});
          check("xmem_cen", inst[19], !xr);
          check("xmem_wen", inst[18], 1'b1);
          if (xr) begin
            if (xq.size() == 0) failNow("xq_underflow");
            else check("xmem_addr", inst[17:7], xq.pop_front());
          end else begin
            check("xmem_addr_idle", inst[17:7], 11'd0);
          end
          check("psum_cen", inst[32], !pw);
          check("psum_wen", inst[31], !pw);
          if (pw) begin
            if (pq.size() == 0) failNow("pq_underflow");
            else check("psum_addr", inst[30:20], pq.pop_front());
          end else begin
            check("psum_addr_idle", inst[30:20], 11'd0);
          end
        end
      end
    end
  end

  // Issue a run: expected addresses go into the scoreboard, start pulses once.
  task automatic runStart(input logic m, input logic [10:0] wb, input logic [10:0] xb,
                          input logic [10:0] pb, input int eb);
    w_base  = wb;
    x_base  = xb;
    p_base  = pb;
    expBusy = eb;
    for (int i = 0; i < 8; i++)  xq.push_back(wb + 11'(i));
    for (int i = 0; i < 36; i++) xq.push_back(xb + 11'(i));
    for (int i = 0; i < 36; i++) pq.push_back(pb + 11'(i));
    mode    = m;
    start   = 1'b1;
    expMode = m;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for the next done pulse; optionally toggle ofifo_valid
  // 1,0,0,1,0,0,... from the last EXEC cycle onward.
  task automatic waitDone(input bit toggle);
    int startCount;
    int j;
    startCount = doneCount;
    j = 0;
    for (int i = 0; i < 400 && doneCount == startCount; i++) begin
      if (toggle && cyc >= 97) begin
        ofifo_valid = (j % 3 == 0);
        j++;
      end
      @(negedge clk); #1;
    end
    if (doneCount == startCount) failNow("done_timeout");
    ofifo_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    mode        = 1'b0;
    w_base      = '0;
    x_base      = '0;
    p_base      = '0;
    ofifo_valid = 1'b1;
    #1;
    check("reset_inst", inst, idleWord);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Basic tile, w_base = 100, ofifo tied high: 134 busy cycles before done.
    runStart(1'b0, 11'd100, 11'd200, 11'd300, 134);
    waitDone(1'b0);

    // Address wrap on xmem and psum sides.
    runStart(1'b0, 11'd2044, 11'd2030, 11'd2040, 134);
    waitDone(1'b0);

    // Gapped drain: writes only after valid edges, addresses contiguous.
    runStart(1'b0, 11'd5, 11'd6, 11'd7, 0);
    waitDone(1'b1);

    // OS mode, start re-pulsed (with mode = 0) during X_RD must be ignored.
    runStart(1'b1, 11'd10, 11'd20, 11'd30, 134);
    repeat (30) @(negedge clk);
    #1;
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    waitDone(1'b0);
    check("done_count_v6", doneCount, 4);

    // Reset in the middle of EXEC, then a clean run.
    runStart(1'b1, 11'd40, 11'd41, 11'd42, 134);
    repeat (70) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_inst", inst, idleWord);
    check("midrun_reset_busy", busy, 1'b0);
    check("midrun_reset_done", done, 1'b0);
    xq.delete();
    pq.delete();
    expMode = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("no_done_after_reset", doneCount, 4);
    runStart(1'b0, 11'd50, 11'd60, 11'd70, 134);
    waitDone(1'b0);

    check("done_total", doneCount, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
